square_tone_generator: RTL and testbench
========================================

Name: square_tone_generator

Overview:
Consumes the 32-bit half-period count produced by the key-to-period lookup and turns it into audio. The count is in clock cycles, and 0 means no key. The block toggles a square-wave phase at that rate and applies a linear attack/release envelope. It hands signed samples to the audio codec interface through a request/valid handshake. It sits between the key lookup and the codec writer in the synthesizer datapath.

Parameters:
SAMPLE_W, 24, width of signed output sample
ENV_DIV, 1024, clock cycles per envelope step
AMP_STEP, 24'h000400, amplitude increment/decrement per envelope step
AMP_MAX, 24'h3FFFFF, envelope ceiling; must be < 2^(SAMPLE_W-1)

Ports:
clock  in  1  system clock
resetn  in  1  synchronous, active-high reset; a 1 on a rising clock edge resets the block
half_period  in  32  half-period in clock cycles from the key lookup; 0 = no note
sample_req  in  1  codec ready for next sample (level)
sample_out  out  SAMPLE_W  signed two's-complement sample
sample_valid  out  1  one-cycle strobe; sample_out valid
tone_active  out  1  high in RUN or RELEASE

Behaviour:
- Reset, when resetn=1 at an edge:
  - state=IDLE; cnt, phase, amp, env_cnt, cur_period = 0.
  - sample_out=0, sample_valid=0, tone_active=0.
  - Reset mid-note aborts the note immediately, with no release.
- env_cnt runs freely 0..ENV_DIV-1. The env_tick condition is env_cnt==ENV_DIV-1.
- IDLE:
  - amp=0, phase=0, cnt=0.
  - If half_period!=0: cur_period<=half_period, cnt<=0, go to RUN next cycle.
- Half-period counting in RUN and RELEASE:
  - cnt increments each cycle.
  - Boundary condition: cnt==cur_period-1. At the boundary: cnt<=0, phase<=~phase.
  - half_period is sampled only at a boundary, which keeps period changes glitch-free. Mid-half-cycle changes are ignored until the next boundary.
  - cur_period=1 toggles phase every cycle.
- RUN:
  - Boundary with half_period!=0: cur_period<=half_period.
  - Boundary with half_period==0: go to RELEASE and keep cur_period.
  - On env_tick: amp<=min(amp+AMP_STEP, AMP_MAX). Compute the sum one bit wider so the add never wraps.
- RELEASE:
  - Square continues at cur_period.
  - On env_tick: amp<=max(amp-AMP_STEP, 0), with no underflow.
  - When amp==0 after an update: go to IDLE; phase and cnt clear.
  - Boundary with half_period!=0: go to RUN with the new cur_period. amp is not reset; the attack resumes from the current amp.
  - If the IDLE transition and a retrigger boundary occur in the same cycle, retrigger wins (RUN).
- Sample handshake:
  - A cycle with sample_req=1 and sample_valid=0 captures sample_out <= phase ? +amp : -amp, sign-extended/negated in SAMPLE_W bits.
  - sample_valid=1 on the following cycle, for exactly one cycle.
  - sample_req held high therefore yields a sample every 2 cycles.
  - sample_out holds its value between strobes.
  - Latency from req to valid is 1 cycle.
  - In IDLE, samples are 0 (negated 0 = 0).
- tone_active is registered and updates with the state.

Decomposition:
- Shared package synth_pkg holds:
  - SAMPLE_W default
  - state enum {IDLE, RUN, RELEASE}
  - AMP_MAX/AMP_STEP defaults
  - the PERIOD_W=32 constant, shared with the key lookup
- Natural sub-module: envelope_ramp.
  - Contains env_cnt, saturating up/down amp.
  - Inputs: up/down/clear. Outputs: amp, at_zero.
- Phase counter and FSM stay in the top module.

Test Plan (sim params ENV_DIV=4, AMP_STEP=24'h100000, AMP_MAX=24'h3FFFFF):
1. Reset: resetn=1 for 2 cycles with half_period=2959 -> sample_out=0, sample_valid=0, tone_active=0, state IDLE; resetn=1 during RUN -> IDLE next cycle, no release.
2. Steady tone: half_period=5 held -> RUN one cycle later; phase toggles every 5 cycles; tone_active=1.
3. Glitch-free change: half_period 5->3 when cnt=2 -> the current half-cycle still lasts 5 cycles; subsequent half-cycles last 3.
4. Attack saturation: amp progresses 0x100000, 0x200000, 0x300000, 0x3FFFFF on successive env_ticks, then holds 0x3FFFFF.
5. Release/retrigger:
   - half_period->0: RELEASE at the next boundary; amp steps down by 0x100000 to 0; then IDLE, tone_active=0.
   - Repeat, but set half_period=3 while amp=0x200000: RUN resumes from 0x200000.
6. Handshake: sample_req held 1 for 4 cycles with phase=0, amp=0x200000 -> two sample_valid strobes 2 cycles apart, sample_out=24'hE00000; with phase=1 -> 24'h200000.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared synthesizer types and defaults.
// Used by the key lookup, the tone generator and the codec writer.
package synth_pkg;

   // Half-period counts coming from the key lookup are this wide.
   localparam int PERIOD_W = 32;

   localparam int SAMPLE_W_DEF = 24;
   localparam int ENV_DIV_DEF  = 1024;

   localparam logic [23:0] AMP_STEP_DEF = 24'h000400;
   localparam logic [23:0] AMP_MAX_DEF  = 24'h3FFFFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      RELEASE = 2'd2
   } state_t;

endpackage

// File: rtl/envelope_ramp.sv
// Linear attack/release envelope: free-running step divider plus a
// saturating amplitude register.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_up          ramp up on each step tick (attack)
//   i_down        ramp down on each step tick (release)
//   i_clear       force amplitude to zero
//   o_amp         current amplitude, never above MAX
//   o_at_zero     a down step taken now would leave the amplitude at zero
//   o_tick        envelope step tick, one cycle in ENV_DIV
module envelope_ramp
   import synth_pkg::*;
#(
   parameter int           W       = SAMPLE_W_DEF,
   parameter int           ENV_DIV = ENV_DIV_DEF,
   parameter logic [W-1:0] STEP    = W'(AMP_STEP_DEF),
   parameter logic [W-1:0] MAX     = W'(AMP_MAX_DEF)
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_up,
   input  logic         i_down,
   input  logic         i_clear,
   output logic [W-1:0] o_amp,
   output logic         o_at_zero,
   output logic         o_tick
);

   localparam int CW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(ENV_DIV - 1);

   logic [CW-1:0] r_env_cnt;
   logic [W-1:0]  r_amp;

   // One bit wider so the attack add can never wrap past zero.
   logic [W:0]    w_sum;
   logic [W-1:0]  w_amp_up;
   logic [W-1:0]  w_amp_dn;

   assign w_sum    = {1'b0, r_amp} + {1'b0, STEP};
   assign w_amp_up = (w_sum > {1'b0, MAX}) ? MAX : w_sum[W-1:0];
   assign w_amp_dn = (r_amp > STEP) ? (r_amp - STEP) : '0;

   assign o_tick    = (r_env_cnt == LAST);
   assign o_at_zero = (w_amp_dn == '0);
   assign o_amp     = r_amp;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_env_cnt <= '0;
         r_amp     <= '0;
      end else begin
         r_env_cnt <= o_tick ? '0 : r_env_cnt + CW'(1);
         if (i_clear)
            r_amp <= '0;
         else if (o_tick && i_up)
            r_amp <= w_amp_up;
         else if (o_tick && i_down)
            r_amp <= w_amp_dn;
      end
   end

endmodule

// File: rtl/square_tone_generator.sv
// Square-wave tone with linear attack/release, fed by half-period counts.
// Ports:
//   clock, resetn   clock, synchronous active-high reset
//   half_period     half-period in cycles from the key lookup, 0 = no key
//   sample_req      codec ready for the next sample (level)
//   sample_out      signed sample, held between strobes
//   sample_valid    one-cycle strobe, sample_out is new
//   tone_active     high while a note sounds (RUN or RELEASE)
module square_tone_generator
   import synth_pkg::*;
#(
   parameter int                  SAMPLE_W = SAMPLE_W_DEF,
   parameter int                  ENV_DIV  = ENV_DIV_DEF,
   parameter logic [SAMPLE_W-1:0] AMP_STEP = SAMPLE_W'(AMP_STEP_DEF),
   parameter logic [SAMPLE_W-1:0] AMP_MAX  = SAMPLE_W'(AMP_MAX_DEF)
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic [PERIOD_W-1:0] half_period,
   input  logic                sample_req,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid,
   output logic                tone_active
);

   state_t              r_state;
   logic [PERIOD_W-1:0] r_cnt;
   logic [PERIOD_W-1:0] r_cur_period;
   logic                r_phase;
   logic [SAMPLE_W-1:0] r_sample_out;
   logic                r_sample_valid;
   logic                r_tone_active;

   logic [SAMPLE_W-1:0] w_amp;
   logic                w_at_zero;
   logic                w_tick;
   logic                w_up;
   logic                w_down;
   logic                w_clear;
   logic                w_hp_nz;
   logic                w_bnd;

   assign w_up    = (r_state == RUN);
   assign w_down  = (r_state == RELEASE);
   assign w_clear = (r_state == IDLE);
   assign w_hp_nz = |half_period;
   // Last cycle of the current half-cycle.
   assign w_bnd   = (r_cnt == r_cur_period - PERIOD_W'(1));

   envelope_ramp #(
      .W       (SAMPLE_W),
      .ENV_DIV (ENV_DIV),
      .STEP    (AMP_STEP),
      .MAX     (AMP_MAX)
   ) u_env (
      .i_clk     (clock),
      .i_rst     (resetn),
      .i_up      (w_up),
      .i_down    (w_down),
      .i_clear   (w_clear),
      .o_amp     (w_amp),
      .o_at_zero (w_at_zero),
      .o_tick    (w_tick)
   );

   always_ff @(posedge clock) begin
      if (resetn) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_cur_period  <= '0;
         r_phase       <= 1'b0;
         r_tone_active <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_cnt   <= '0;
               r_phase <= 1'b0;
               if (w_hp_nz) begin
                  r_cur_period  <= half_period;
                  r_state       <= RUN;
                  r_tone_active <= 1'b1;
               end
            end
            RUN: begin
               if (w_bnd) begin
                  r_cnt   <= '0;
                  r_phase <= ~r_phase;
                  // New period is only taken at a boundary.
                  if (w_hp_nz)
                     r_cur_period <= half_period;
                  else
                     r_state <= RELEASE;
               end else begin
                  r_cnt <= r_cnt + PERIOD_W'(1);
               end
            end
            RELEASE: begin
               // Retrigger beats the fall to IDLE in the same cycle.
               if (w_bnd && w_hp_nz) begin
                  r_cnt        <= '0;
                  r_phase      <= ~r_phase;
                  r_cur_period <= half_period;
                  r_state      <= RUN;
               end else if (w_tick && w_at_zero) begin
                  r_cnt         <= '0;
                  r_phase       <= 1'b0;
                  r_state       <= IDLE;
                  r_tone_active <= 1'b0;
               end else if (w_bnd) begin
                  r_cnt   <= '0;
                  r_phase <= ~r_phase;
               end else begin
                  r_cnt <= r_cnt + PERIOD_W'(1);
               end
            end
            default: begin
               r_state       <= IDLE;
               r_tone_active <= 1'b0;
            end
         endcase
      end
   end

   // A request is served only when no strobe is out, so a held
   // request yields one sample every other cycle.
   always_ff @(posedge clock) begin
      if (resetn) begin
         r_sample_out   <= '0;
         r_sample_valid <= 1'b0;
      end else if (sample_req && !r_sample_valid) begin
         r_sample_out   <= r_phase ? w_amp : (~w_amp + SAMPLE_W'(1));
         r_sample_valid <= 1'b1;
      end else begin
         r_sample_valid <= 1'b0;
      end
   end

   assign sample_out   = r_sample_out;
   assign sample_valid = r_sample_valid;
   assign tone_active  = r_tone_active;

endmodule

// File: tb/tb_square_tone_generator.sv
// Randomized bench for square_tone_generator against a cycle model
// built from the note/envelope/handshake rules.
module tb_square_tone_generator;

   localparam int          SW   = 24;
   localparam int          EDIV = 4;
   localparam longint      STEP = 64'h100000;
   localparam longint      AMAX = 64'h3FFFFF;

   logic          clock;
   logic          resetn;
   logic [31:0]   half_period;
   logic          sample_req;
   logic [SW-1:0] sample_out;
   logic          sample_valid;
   logic          tone_active;

   int n_total;
   int n_bad;

   // Reference model state: mode 0 = silent, 1 = attack/hold, 2 = release.
   int            m_mode;
   longint        m_cnt;
   longint        m_per;
   logic          m_ph;
   longint        m_amp;
   int            m_env;
   logic          m_sv;
   logic [SW-1:0] m_so;
   logic          m_ta;

   square_tone_generator #(
      .SAMPLE_W (SW),
      .ENV_DIV  (EDIV),
      .AMP_STEP (24'h100000),
      .AMP_MAX  (24'h3FFFFF)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .half_period  (half_period),
      .sample_req   (sample_req),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .tone_active  (tone_active)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic [31:0] hp, input logic req,
                             input logic rst);
      logic   tick;
      logic   bnd;
      longint na;
      if (rst) begin
         m_mode = 0; m_cnt = 0; m_per = 0; m_ph = 0; m_amp = 0;
         m_env = 0; m_sv = 0; m_so = '0; m_ta = 0;
         return;
      end
      // Sample from the values present before this edge.
      if (req && !m_sv) begin
         m_so = m_ph ? SW'(m_amp) : SW'(-m_amp);
         m_sv = 1'b1;
      end else begin
         m_sv = 1'b0;
      end
      tick  = (m_env == EDIV - 1);
      m_env = (m_env + 1) % EDIV;
      na    = m_amp;
      bnd   = (m_mode != 0) && (m_cnt == m_per - 1);
      if (m_mode != 0) begin
         if (bnd) begin
            m_cnt = 0;
            m_ph  = ~m_ph;
         end else begin
            m_cnt = m_cnt + 1;
         end
      end
      case (m_mode)
         0: begin
            na = 0;
            if (hp != 0) begin
               m_mode = 1;
               m_per  = hp;
               m_cnt  = 0;
            end
         end
         1: begin
            if (tick) na = (m_amp + STEP > AMAX) ? AMAX : m_amp + STEP;
            if (bnd) begin
               if (hp != 0) m_per = hp;
               else m_mode = 2;
            end
         end
         default: begin
            if (tick) na = (m_amp - STEP < 0) ? 0 : m_amp - STEP;
            if (bnd && hp != 0) begin
               m_mode = 1;
               m_per  = hp;
            end else if (tick && na == 0) begin
               m_mode = 0;
               m_ph   = 0;
               m_cnt  = 0;
            end
         end
      endcase
      m_amp = na;
      m_ta  = (m_mode != 0);
   endtask

   task automatic cyc(input logic [31:0] hp, input logic req,
                      input logic rst);
      half_period = hp;
      sample_req  = req;
      resetn      = rst;
      @(posedge clock);
      model_step(hp, req, rst);
      #1;
      check("valid", {31'd0, sample_valid}, {31'd0, m_sv});
      check("out", {8'd0, sample_out}, {8'd0, m_so});
      check("active", {31'd0, tone_active}, {31'd0, m_ta});
      @(negedge clock);
   endtask

   task automatic run(input logic [31:0] hp, input int req_mode,
                      input int n);
      logic r;
      for (int i = 0; i < n; i++) begin
         r = (req_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(req_mode);
         cyc(hp, r, 1'b0);
      end
   endtask

   initial begin
      int hp_tab [8];
      int seg_hp;
      int seg_req;
      int seg_len;
      hp_tab = '{0, 1, 2, 3, 4, 5, 9, 0};
      n_total = 0;
      n_bad   = 0;
      half_period = '0;
      sample_req  = 1'b0;
      resetn      = 1'b1;

      // Reset held with a key pressed.
      cyc(32'd2959, 1'b1, 1'b1);
      cyc(32'd2959, 1'b1, 1'b1);
      check("rst_out", {8'd0, sample_out}, 32'd0);
      check("rst_valid", {31'd0, sample_valid}, 32'd0);
      check("rst_active", {31'd0, tone_active}, 32'd0);

      // Steady tone, then reset mid-note.
      run(32'd5, 1, 30);
      check("run_active", {31'd0, tone_active}, 32'd1);
      cyc(32'd5, 1'b1, 1'b1);
      check("abort_active", {31'd0, tone_active}, 32'd0);
      check("abort_valid", {31'd0, sample_valid}, 32'd0);

      // Period change mid half-cycle, then attack to saturation.
      run(32'd5, 1, 4);
      run(32'd3, 1, 40);
      // Release all the way down.
      run(32'd0, 1, 40);
      check("release_idle", {31'd0, tone_active}, 32'd0);
      check("idle_out", {8'd0, sample_out}, 32'd0);

      // Partial attack, release, then retrigger.
      run(32'd7, 1, 14);
      run(32'd0, 1, 12);
      run(32'd3, 1, 20);
      run(32'd0, 2, 30);

      // Fastest tone toggles every cycle.
      run(32'd1, 1, 20);
      run(32'd0, 1, 30);

      // Random segments.
      for (int s = 0; s < 60; s++) begin
         seg_hp  = hp_tab[$urandom_range(0, 7)];
         seg_req = $urandom_range(0, 2);
         seg_len = $urandom_range(1, 25);
         if ($urandom_range(0, 29) == 0)
            cyc(32'(seg_hp), 1'b0, 1'b1);
         run(32'(seg_hp), seg_req, seg_len);
      end
      run(32'd0, 2, 40);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
